// File: rtl/prom_responder.sv
// ============================================================================
// Module   : prom_responder
// Function : Boot-PROM responder. It assembles 49-bit microinstructions from
//            four 16-bit boot-ROM beats and holds the last fetched word so
//            that repeat requests are answered immediately.
// Options  : PROM_PARITY_EN enables the odd-parity check over the held word.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module prom_responder #(
    parameter int BEATS  = 4,
    parameter int ROM_AW = 11
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              promce,
    input  logic [8:0]        promaddr,
    output logic [48:0]       iprom,
    output logic              prom_ready,
    output logic              rom_en,
    output logic [ROM_AW-1:0] rom_addr,
    input  logic [15:0]       rom_data,
    output logic              prom_parity_err
);

    localparam int            BW        = $clog2(BEATS);
    localparam logic [BW-1:0] LAST_BEAT = BW'(BEATS - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t              state, state_nx;
    logic [8:0]          req_addr, req_addr_nx;
    logic                rom_en_nx;
    logic [ROM_AW-1:0]   rom_addr_nx;
    logic                cap_valid, cap_valid_nx;
    logic [BW-1:0]       cap_beat, cap_beat_nx;
    logic                held_valid, held_valid_nx;
    logic [8:0]          held_addr, held_addr_nx;
    logic [48:0]         held_word, held_word_nx;
    logic                hit;
    logic                abort;

    assign hit        = promce && held_valid && (held_addr == promaddr);
    assign prom_ready = hit;
    // Zero when not ready so the shared IR bus can be wire-ORed.
    assign iprom      = hit ? held_word : 49'd0;
    assign abort      = !promce || (promaddr != req_addr);

    always_comb begin
        state_nx      = state;
        req_addr_nx   = req_addr;
        rom_en_nx     = 1'b0;
        rom_addr_nx   = rom_addr;
        cap_valid_nx  = rom_en && !abort;
        cap_beat_nx   = rom_addr[BW-1:0];
        held_valid_nx = held_valid;
        held_addr_nx  = held_addr;
        held_word_nx  = held_word;

        // Beat data lands one cycle after its issue; an abort discards it.
        if (cap_valid && !abort) begin
            case (cap_beat)
                2'd0:    held_word_nx[15:0]  = rom_data;
                2'd1:    held_word_nx[31:16] = rom_data;
                2'd2:    held_word_nx[47:32] = rom_data;
                default: held_word_nx[48]    = rom_data[0];
            endcase
        end

        case (state)
            IDLE: begin
                if (promce && !hit) begin
                    req_addr_nx   = promaddr;
                    held_valid_nx = 1'b0;
                    rom_en_nx     = 1'b1;
                    rom_addr_nx   = {promaddr, {BW{1'b0}}};
                    state_nx      = ISSUE;
                end
            end
            ISSUE: begin
                if (abort) begin
                    state_nx = IDLE;
                end else if (rom_addr[BW-1:0] == LAST_BEAT) begin
                    state_nx = DRAIN;
                end else begin
                    rom_en_nx   = 1'b1;
                    rom_addr_nx = {req_addr, rom_addr[BW-1:0] + BW'(1)};
                end
            end
            DRAIN: begin
                if (!abort) begin
                    held_addr_nx  = req_addr;
                    held_valid_nx = 1'b1;
                end
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            req_addr   <= 9'd0;
            rom_en     <= 1'b0;
            rom_addr   <= '0;
            cap_valid  <= 1'b0;
            cap_beat   <= '0;
            held_valid <= 1'b0;
            held_addr  <= 9'd0;
            held_word  <= 49'd0;
        end else begin
            state      <= state_nx;
            req_addr   <= req_addr_nx;
            rom_en     <= rom_en_nx;
            rom_addr   <= rom_addr_nx;
            cap_valid  <= cap_valid_nx;
            cap_beat   <= cap_beat_nx;
            held_valid <= held_valid_nx;
            held_addr  <= held_addr_nx;
            held_word  <= held_word_nx;
        end
    end

`ifdef PROM_PARITY_EN
    logic parity_err, parity_err_nx;

    // Bit 48 is the parity bit; the full 49-bit word must have odd parity.
    always_comb begin
        parity_err_nx = parity_err;
        if (state == IDLE && promce && !hit) begin
            parity_err_nx = 1'b0;
        end else if (state == DRAIN && !abort) begin
            parity_err_nx = ~^held_word_nx;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            parity_err <= 1'b0;
        end else begin
            parity_err <= parity_err_nx;
        end
    end

    assign prom_parity_err = parity_err && hit;
`else
    assign prom_parity_err = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_prom_responder.sv
// ============================================================================
// Module   : tb_prom_responder
// Function : Directed self-checking bench for prom_responder.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_prom_responder;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        promce = 1'b0;
    logic [8:0]  promaddr = 9'd0;
    logic [48:0] iprom;
    logic        prom_ready;
    logic        rom_en;
    logic [10:0] rom_addr;
    logic [15:0] rom_data = 16'd0;
    logic        prom_parity_err;

    int   n_checks = 0;
    int   n_fail   = 0;
    logic flip48   = 1'b0;

`ifdef PROM_PARITY_EN
    localparam logic PARITY_ON = 1'b1;
`else
    localparam logic PARITY_ON = 1'b0;
`endif

    always #5 clk = ~clk;

    prom_responder dut (
        .clk             (clk),
        .reset           (reset),
        .promce          (promce),
        .promaddr        (promaddr),
        .iprom           (iprom),
        .prom_ready      (prom_ready),
        .rom_en          (rom_en),
        .rom_addr        (rom_addr),
        .rom_data        (rom_data),
        .prom_parity_err (prom_parity_err)
    );

    // Word 0 uses the listed test pattern; every other word is derived from its address.
    function automatic logic [15:0] model_beat(input logic [8:0] a, input logic [1:0] k);
        logic [15:0] d;
        if (a == 9'd0) begin
            case (k)
                2'd0:    d = 16'h1111;
                2'd1:    d = 16'h2222;
                2'd2:    d = 16'h3333;
                default: d = 16'h0001;
            endcase
        end else begin
            d = {2'b00, k, 3'b000, a};
        end
        if (k == 2'd3) d[0] = d[0] ^ flip48;
        return d;
    endfunction

    function automatic logic [48:0] expected_word(input logic [8:0] a);
        logic [15:0] b0, b1, b2, b3;
        b0 = model_beat(a, 2'd0);
        b1 = model_beat(a, 2'd1);
        b2 = model_beat(a, 2'd2);
        b3 = model_beat(a, 2'd3);
        return {b3[0], b2, b1, b0};
    endfunction

    function automatic logic exp_perr(input logic [48:0] w);
        return PARITY_ON & ~^w;
    endfunction

    always @(posedge clk) begin
        if (rom_en) rom_data <= model_beat(rom_addr[10:2], rom_addr[1:0]);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_word(input string tag, input logic [8:0] a);
        logic [48:0] w;
        w = expected_word(a);
        chk({tag, ".ready"}, 64'(prom_ready), 64'd1);
        chk({tag, ".iprom"}, 64'(iprom), 64'(w));
        chk({tag, ".perr"}, 64'(prom_parity_err), 64'(exp_perr(w)));
    endtask

    initial begin
        // Reset state
        tick(); tick(); tick();
        chk("rst.rom_en", 64'(rom_en), 64'd0);
        chk("rst.rom_addr", 64'(rom_addr), 64'd0);
        chk("rst.ready", 64'(prom_ready), 64'd0);
        chk("rst.iprom", 64'(iprom), 64'd0);
        chk("rst.perr", 64'(prom_parity_err), 64'd0);

        // First fetch of word 0
        reset = 1'b0; promce = 1'b1; promaddr = 9'h000;
        #1;
        chk("f0.ready_n", 64'(prom_ready), 64'd0);
        for (int k = 0; k < 4; k++) begin
            tick();
            chk("f0.rom_en", 64'(rom_en), 64'd1);
            chk("f0.rom_addr", 64'(rom_addr), 64'(k));
        end
        tick();
        chk("f0.drain_en", 64'(rom_en), 64'd0);
        chk("f0.drain_ready", 64'(prom_ready), 64'd0);
        tick();
        chk("f0.iprom_lit", 64'(iprom), 64'h1_3333_2222_1111);
        chk_word("f0", 9'h000);

        // Drop promce, then hit with no refetch
        promce = 1'b0;
        #1;
        chk("idle.ready", 64'(prom_ready), 64'd0);
        chk("idle.iprom", 64'(iprom), 64'd0);
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("idle.rom_en", 64'(rom_en), 64'd0);
        end
        promce = 1'b1;
        #1;
        chk_word("hit", 9'h000);
        tick();
        chk("hit.rom_en", 64'(rom_en), 64'd0);
        chk("hit.ready", 64'(prom_ready), 64'd1);

        // Abort after beat 2 of word 5, restart on word 6
        promaddr = 9'h005;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("ab.rom_addr", 64'(rom_addr), 64'(11'h014 + 11'(k)));
        end
        promaddr = 9'h006;
        tick();
        chk("ab.rom_en_drop", 64'(rom_en), 64'd0);
        for (int k = 0; k < 4; k++) begin
            tick();
            chk("ab.re_en", 64'(rom_en), 64'd1);
            chk("ab.re_addr", 64'(rom_addr), 64'(11'h018 + 11'(k)));
        end
        tick();
        chk("ab.drain_ready", 64'(prom_ready), 64'd0);
        tick();
        chk_word("ab", 9'h006);

        // Top address, then wrap to 0
        promaddr = 9'h1FF;
        for (int k = 0; k < 4; k++) begin
            tick();
            chk("top.rom_addr", 64'(rom_addr), 64'(11'h7FC + 11'(k)));
        end
        tick(); tick();
        chk_word("top", 9'h1FF);
        promaddr = 9'h000;
        #1;
        chk("wrap.miss", 64'(prom_ready), 64'd0);
        tick();
        chk("wrap.rom_en", 64'(rom_en), 64'd1);
        chk("wrap.rom_addr", 64'(rom_addr), 64'd0);
        for (int k = 0; k < 5; k++) tick();
        chk_word("wrap", 9'h000);

        // Reset during beat 1, then full refetch
        promaddr = 9'h003;
        tick();
        chk("mr.beat0", 64'(rom_addr), 64'h00C);
        tick();
        chk("mr.beat1", 64'(rom_addr), 64'h00D);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        #1;
        chk("mr.rom_en", 64'(rom_en), 64'd0);
        chk("mr.ready", 64'(prom_ready), 64'd0);
        chk("mr.iprom", 64'(iprom), 64'd0);
        for (int k = 0; k < 4; k++) begin
            tick();
            chk("mr.re_en", 64'(rom_en), 64'd1);
            chk("mr.re_addr", 64'(rom_addr), 64'(11'h00C + 11'(k)));
        end
        tick(); tick();
        chk_word("mr", 9'h003);

        // Bit 48 flipped: word 6 now has odd parity
        flip48 = 1'b1;
        promaddr = 9'h006;
        for (int k = 0; k < 6; k++) tick();
        chk_word("par", 9'h006);
        promce = 1'b0;
        #1;
        chk("par.gated", 64'(prom_parity_err), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/prom_responder.md
Name: prom_responder

Overview:
- Answers the boot-PROM requests issued by the PROM control logic (promce, promaddr[8:0]) and returns a 49-bit microinstruction (iprom) with a ready flag.
- Backing store is a narrow 16-bit synchronous boot ROM. Each microinstruction takes 4 beats, which this block sequences and assembles.
- Holds the last fetched word, so a repeated address is answered without refetching.
- Sits between PROM control and the boot ROM macro, in front of the instruction-register mux.

Parameters:
- BEATS, 4, ROM beats per microinstruction. Fixed at 4: 4 x 16 = 64 bits, low 49 used.
- ROM_AW, 11, ROM address width = 9 + log2(BEATS).

Ports:
- clk  input  1  system clock
- reset  input  1  synchronous, active-high reset
- promce  input  1  PROM chip enable from PROM control; a request is active while high
- promaddr  input  9  PROM word address
- iprom  output  49  assembled microinstruction; 0 when not ready
- prom_ready  output  1  iprom is valid for the current promaddr
- rom_en  output  1  boot ROM read enable, registered
- rom_addr  output  11  boot ROM address {word_addr, beat[1:0]}, registered
- rom_data  input  16  boot ROM read data; valid the cycle after rom_en
- prom_parity_err  output  1  parity error flag (see Optional Feature)

Behaviour:
- All ports sample and drive on the rising edge of clk. Reset is synchronous, active-high; no asynchronous paths.
- Reset values: state IDLE; held_valid 0; held_addr 0; held_word 0; rom_en 0; rom_addr 0; prom_ready 0; iprom 0; prom_parity_err 0.
- Hit definition: hit = promce & held_valid & (held_addr == promaddr).
- prom_ready = hit (combinational).
- iprom = hit ? held_word[48:0] : 0. The zero output keeps the wired-OR IR bus clean.
- States: IDLE, ISSUE, DRAIN.
- IDLE:
  - If promce & ~hit: latch req_addr = promaddr, clear held_valid, beat = 0, go to ISSUE.
  - Otherwise stay in IDLE.
- ISSUE:
  - Each cycle: rom_en = 1, rom_addr = {req_addr, beat}, beat += 1.
  - After beat 3 is issued, go to DRAIN.
- Data capture (ISSUE and DRAIN):
  - The rom_data returned for beat k is written into held_word[16k+15:16k] one cycle after that beat is issued.
- DRAIN:
  - Capture the beat-3 data; held_addr = req_addr; held_valid = 1; go to IDLE.
- Latency: request first seen in cycle N -> rom_en high in cycles N+1..N+4 -> held_valid set at the end of N+5 -> prom_ready high in N+6 (6 cycles). A hit is answered in 0 cycles.
- Abort conditions, checked in ISSUE or DRAIN:
  - promce low, or promaddr != req_addr.
  - Action: drop rom_en, discard partial data, keep held_valid = 0, return to IDLE.
  - IDLE then restarts the fetch on the next cycle if a request is present.
- promce low in IDLE: no ROM activity and prom_ready = 0. Held data is retained for a later hit.
- Address wrap: 511 -> 0 has no special handling; rom_addr is exactly {promaddr, beat}.
- Reset mid-fetch: returns to IDLE within the same cycle. held_valid = 0 and rom_en = 0 on the next cycle.
- held_word[63:49] is ignored.

Optional Feature:
- Macro: PROM_PARITY_EN.
- Defined:
  - prom_parity_err is registered and updates when DRAIN completes.
  - It is 1 when the XOR of held_word[48:0] is 0, i.e. odd parity over the 49 bits (bit 48 is the parity bit) fails.
  - It is cleared by reset or by the start of a new fetch.
  - It is exported only while prom_ready is high; otherwise it reads 0.
- Not defined: prom_parity_err is tied to 0 and no parity logic is synthesized.

Test Plan:
- Reset, then promce = 1, promaddr = 9'h000, ROM model returning beats 16'h1111 / 16'h2222 / 16'h3333 / 16'h0001:
  - rom_addr = 0, 1, 2, 3 in cycles 1-4.
  - prom_ready rises in cycle 6.
  - iprom = 49'h1_3333_2222_1111.
- Hold promaddr = 0 after ready, drop promce for 3 cycles, then raise it again: prom_ready is high the same cycle and rom_en stays 0 (hit).
- promaddr changes from 9'h005 to 9'h006 after the beat-2 issue:
  - Fetch aborts and rom_en drops.
  - A new fetch starts at rom_addr = 11'h018.
  - iprom holds the word for address 6 and prom_ready is high in the 7th cycle after the change.
- promaddr = 9'h1FF: rom_addr = 11'h7FC..11'h7FF. Then promaddr = 9'h000 misses and rom_addr restarts at 0.
- reset asserted during beat 1:
  - Next cycle: rom_en = 0, prom_ready = 0, state IDLE.
  - A re-request of the same address performs a full 4-beat fetch.
- With PROM_PARITY_EN, a word whose 49-bit XOR is 0: prom_parity_err = 1 with prom_ready. Flipping bit 48 in the model makes prom_parity_err = 0.
